dmu_sio_rcv: RTL and testbench
==============================

// Module: dmu_sio_rcv
// PURPOSE
//  DMU-side receive stage for the SIU->DMU outbound path (DMA read returns, PIO).
//  Captures each SIU packet: header cycle, then optionally 4 x 128b payload beats (64 B).
//  Checks lane parity on every beat and buffers beats in a FIFO for the DMU core.
//  The SIU cannot be stalled, so the block admits or drops whole packets at header time.
// PARAMETERS
//  DEPTH   16  FIFO depth in beats; power of 2, >= 5
//  CNT_W   8   width of saturating error counters
// PORTS
//  iol2clk          in   1    clock; all logic on posedge
//  rst              in   1    asynchronous, active-high reset
//  sio_dmu_hdr_vld  in   1    header cycle strobe
//  sio_dmu_datareq  in   1    sampled with hdr_vld: 1 = 4 payload beats follow
//  sio_dmu_data     in   128  header/payload beat
//  sio_dmu_parity   in   8    parity[i] = ^data[16i+15:16i] (even, per 16b lane)
//  rcv_vld          out  1    FIFO head beat valid
//  rcv_rdy          in   1    consumer accepts head beat when rcv_vld & rcv_rdy
//  rcv_data         out  128  head beat data
//  rcv_sop          out  1    head beat is a header
//  rcv_eop          out  1    head beat is last beat of its packet
//  rcv_perr         out  1    head beat failed lane parity
//  rcv_free         out  log2(DEPTH)+1  free FIFO entries
//  err_proto        out  1    1-cycle pulse: hdr_vld seen while in PAYLOAD
//  perr_cnt         out  CNT_W  saturating count of beats with parity error
//  drop_cnt         out  CNT_W  saturating count of dropped packets
// BEHAVIOUR
//  Reset (async, any time): FSM->IDLE, beat_cnt=0, FIFO emptied (rd=wr ptr=0),
//   rcv_vld=0, rcv_sop/eop/perr=0, rcv_data=0, rcv_free=DEPTH, err_proto=0,
//   perr_cnt=0, drop_cnt=0. A packet in flight at reset is discarded; beats after
//   deassertion are ignored until next hdr_vld.
//  FSM states: IDLE, PAYLOAD, DROP.
//   IDLE, hdr_vld=1: need = datareq ? 5 : 1. If rcv_free >= need: write header
//    beat (sop=1, eop=~datareq); ->PAYLOAD if datareq else stay IDLE.
//    Otherwise drop_cnt++ (sat); ->DROP if datareq else stay IDLE; nothing written.
//   PAYLOAD: payload beats are the 4 cycles right after the header (T+1..T+4),
//    unconditional on hdr_vld. beat_cnt 0..3; write beat each cycle (sop=0,
//    eop=(beat_cnt==3)); at beat_cnt==3 -> IDLE, beat_cnt=0.
//   DROP: count 4 cycles identically, write nothing, -> IDLE.
//   hdr_vld=1 in PAYLOAD/DROP: err_proto=1 next cycle; beat is treated as payload
//    (not a new header); datareq ignored.
//  Parity: computed on every accepted beat (header and payload); mismatch sets
//   stored perr bit and perr_cnt++ (sat at 2^CNT_W-1). Dropped beats not checked.
//  FIFO: beat written at edge T is visible on rcv_* from T+1 (1-cycle latency).
//   rcv_* are combinational reads of head entry; hold stable while vld & ~rdy.
//   Pop on vld&rdy. Simultaneous push+pop: free unchanged, both pointers advance.
//   Pointers wrap modulo DEPTH; full/empty distinguished by extra pointer MSB.
//   Admission at header guarantees no push to a full FIFO; overflow impossible.
//   rcv_free = DEPTH - occupancy, registered, updated every edge.
//  Counters: saturate, never wrap; cleared only by rst.
// TESTING
//  1. Header 0x...A5, datareq=0, good parity, rdy=1 -> T+1 one beat vld,sop=1,eop=1,perr=0.
//  2. Header+datareq=1, beats D0..D3, rdy=1 -> 5 beats T+1..T+5, eop only on D3; free back to 16.
//  3. D2 lane 3 parity flipped -> only D2 has perr=1; perr_cnt=1.
//  4. rdy=0, send 3 full pkts (15 beats, free=1), 4th header datareq=1 -> dropped,
//     drop_cnt=1, its 4 beats not stored; next datareq=0 header with free=1 accepted.
//  5. hdr_vld asserted on payload beat 2 -> err_proto pulse 1 cycle, packet still 5 beats.
//  6. rst asserted mid-payload (beat 1), rdy=0 -> rcv_vld=0, free=16 immediately; remaining beats ignored.

Source files
------------

// File: rtl/dmu_sio_rcv_if.sv
// dmu_sio_rcv_if: SIU packet input and DMU core receive-side signals of dmu_sio_rcv
interface dmu_sio_rcv_if #(parameter int DEPTH = 16, parameter int CNT_W = 8);
  logic                     sio_dmu_hdr_vld;
  logic                     sio_dmu_datareq;
  logic [127:0]             sio_dmu_data;
  logic [7:0]               sio_dmu_parity;
  logic                     rcv_vld;
  logic                     rcv_rdy;
  logic [127:0]             rcv_data;
  logic                     rcv_sop;
  logic                     rcv_eop;
  logic                     rcv_perr;
  logic [$clog2(DEPTH):0]   rcv_free;
  logic                     err_proto;
  logic [CNT_W-1:0]         perr_cnt;
  logic [CNT_W-1:0]         drop_cnt;
  modport master (
    output sio_dmu_hdr_vld, sio_dmu_datareq, sio_dmu_data, sio_dmu_parity, rcv_rdy,
    input  rcv_vld, rcv_data, rcv_sop, rcv_eop, rcv_perr, rcv_free, err_proto, perr_cnt, drop_cnt
  );
  modport slave (
    input  sio_dmu_hdr_vld, sio_dmu_datareq, sio_dmu_data, sio_dmu_parity, rcv_rdy,
    output rcv_vld, rcv_data, rcv_sop, rcv_eop, rcv_perr, rcv_free, err_proto, perr_cnt, drop_cnt
  );
endinterface

// File: rtl/dmu_sio_rcv.sv
// dmu_sio_rcv: SIU->DMU packet capture with header-time admission, lane parity check and beat FIFO
module dmu_sio_rcv #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
) (
  input logic iol2clk,
  input logic rst,
  dmu_sio_rcv_if.slave s
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;
  state_t st;
  logic [1:0] beat_cnt;
  logic [AW:0] wp, rp, free;
  logic [130:0] mem [DEPTH];
  logic [130:0] head;
  logic [7:0] lane_par;
  logic hdr, admit, push, pop, perr, push_sop, push_eop;
  logic [AW:0] need;
  always_comb begin
    for (int i = 0; i < 8; i++) lane_par[i] = ^s.sio_dmu_data[16*i +: 16];
  end
  assign perr     = |(lane_par ^ s.sio_dmu_parity);
  assign hdr      = (st == IDLE) && s.sio_dmu_hdr_vld;
  assign need     = s.sio_dmu_datareq ? (AW+1)'(5) : (AW+1)'(1);
  assign admit    = hdr && (free >= need);
  assign push     = admit || (st == PAYLOAD);
  assign push_sop = (st == IDLE);
  assign push_eop = (st == IDLE) ? ~s.sio_dmu_datareq : (beat_cnt == 2'd3);
  assign pop      = s.rcv_vld && s.rcv_rdy;
  // Empty head reads as zero so rcv_* are clean out of reset and between packets
  assign s.rcv_vld  = (wp != rp);
  assign head       = s.rcv_vld ? mem[rp[AW-1:0]] : '0;
  assign s.rcv_data = head[130:3];
  assign s.rcv_sop  = head[2];
  assign s.rcv_eop  = head[1];
  assign s.rcv_perr = head[0];
  assign s.rcv_free = free;
  always_ff @(posedge iol2clk) begin
    if (push) mem[wp[AW-1:0]] <= {s.sio_dmu_data, push_sop, push_eop, perr};
  end
  always_ff @(posedge iol2clk or posedge rst) begin
    if (rst) begin
      st          <= IDLE;
      beat_cnt    <= '0;
      wp          <= '0;
      rp          <= '0;
      free        <= (AW+1)'(DEPTH);
      s.err_proto <= 1'b0;
      s.perr_cnt  <= '0;
      s.drop_cnt  <= '0;
    end else begin
      wp          <= wp + (AW+1)'(push);
      rp          <= rp + (AW+1)'(pop);
      free        <= free - (AW+1)'(push) + (AW+1)'(pop);
      s.err_proto <= s.sio_dmu_hdr_vld && (st != IDLE);
      if (push && perr && ~&s.perr_cnt) s.perr_cnt <= s.perr_cnt + 1'b1;
      if (hdr && !admit && ~&s.drop_cnt) s.drop_cnt <= s.drop_cnt + 1'b1;
      if (st == IDLE) begin
        if (hdr && s.sio_dmu_datareq) st <= admit ? PAYLOAD : DROP;
      end else begin
        beat_cnt <= beat_cnt + 2'd1;
        if (beat_cnt == 2'd3) st <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_dmu_sio_rcv.sv
// tb_dmu_sio_rcv: directed scenario tests for dmu_sio_rcv
module tb_dmu_sio_rcv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  dmu_sio_rcv_if #(.DEPTH(16), .CNT_W(8)) bus ();
  dmu_sio_rcv #(.DEPTH(16), .CNT_W(8)) dut (.iol2clk(clk), .rst(rst), .s(bus.slave));
  always #5 clk = ~clk;
  function automatic logic [7:0] par(input logic [127:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = ^d[16*i +: 16];
    return p;
  endfunction
  function automatic logic [127:0] mkd(input int p, input int b);
    return {32'hC0DE_0000 | 32'(p * 16 + b), 32'h1357_9BDF ^ 32'(b), 32'(p), 32'h0F0F_00A0 | 32'(b)};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic h, input logic r, input logic [127:0] d, input logic [7:0] flip);
    bus.sio_dmu_hdr_vld = h;
    bus.sio_dmu_datareq = r;
    bus.sio_dmu_data    = d;
    bus.sio_dmu_parity  = par(d) ^ flip;
  endtask
  task automatic idle;
    drive(1'b0, 1'b0, '0, 8'h00);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    total++; if (bus.rcv_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", bus.rcv_vld); end
    total++; if (bus.rcv_free !== 5'd16) begin bad++; $display("FAIL reset_free got=%0d exp=16", bus.rcv_free); end
    total++; if (bus.rcv_data !== 128'd0 || bus.rcv_sop !== 1'b0 || bus.rcv_eop !== 1'b0 || bus.rcv_perr !== 1'b0)
      begin bad++; $display("FAIL reset_head got=%h/%b%b%b exp=0", bus.rcv_data, bus.rcv_sop, bus.rcv_eop, bus.rcv_perr); end
    total++; if (bus.err_proto !== 1'b0 || bus.perr_cnt !== 8'd0 || bus.drop_cnt !== 8'd0)
      begin bad++; $display("FAIL reset_cnt got=%b/%0d/%0d exp=0/0/0", bus.err_proto, bus.perr_cnt, bus.drop_cnt); end
    rst = 1'b0;
    tick;
  endtask
  task automatic test_single_hdr;
    logic [127:0] d;
    d = 128'h0000_0000_0000_0000_0000_0000_0000_00A5;
    bus.rcv_rdy = 1'b1;
    drive(1'b1, 1'b0, d, 8'h00);
    tick;
    idle;
    total++; if ({bus.rcv_vld, bus.rcv_sop, bus.rcv_eop, bus.rcv_perr} !== 4'b1110)
      begin bad++; $display("FAIL hdr_flags got=%b exp=1110", {bus.rcv_vld, bus.rcv_sop, bus.rcv_eop, bus.rcv_perr}); end
    total++; if (bus.rcv_data !== d) begin bad++; $display("FAIL hdr_data got=%h exp=%h", bus.rcv_data, d); end
    total++; if (bus.rcv_free !== 5'd15) begin bad++; $display("FAIL hdr_free got=%0d exp=15", bus.rcv_free); end
    tick;
    total++; if (bus.rcv_vld !== 1'b0 || bus.rcv_free !== 5'd16)
      begin bad++; $display("FAIL hdr_pop got=%b/%0d exp=0/16", bus.rcv_vld, bus.rcv_free); end
  endtask
  task automatic run_pkt(input int p, input int flip_beat, input logic [7:0] flip);
    bus.rcv_rdy = 1'b1;
    for (int b = 0; b < 5; b++) begin
      drive(b == 0, b == 0, mkd(p, b), (b == flip_beat) ? flip : 8'h00);
      tick;
      total++; if (bus.rcv_vld !== 1'b1 || bus.rcv_data !== mkd(p, b))
        begin bad++; $display("FAIL pkt%0d_beat%0d_data got=%b/%h exp=1/%h", p, b, bus.rcv_vld, bus.rcv_data, mkd(p, b)); end
      total++; if ({bus.rcv_sop, bus.rcv_eop, bus.rcv_perr} !== {b == 0, b == 4, b == flip_beat})
        begin bad++; $display("FAIL pkt%0d_beat%0d_flags got=%b exp=%b", p, b, {bus.rcv_sop, bus.rcv_eop, bus.rcv_perr}, {b == 0, b == 4, b == flip_beat}); end
    end
    idle;
    tick;
    total++; if (bus.rcv_vld !== 1'b0 || bus.rcv_free !== 5'd16)
      begin bad++; $display("FAIL pkt%0d_end got=%b/%0d exp=0/16", p, bus.rcv_vld, bus.rcv_free); end
  endtask
  task automatic test_full_pkt;
    run_pkt(1, 9, 8'h00);
  endtask
  task automatic test_parity;
    run_pkt(2, 3, 8'h08);
    total++; if (bus.perr_cnt !== 8'd1) begin bad++; $display("FAIL perr_cnt got=%0d exp=1", bus.perr_cnt); end
  endtask
  task automatic test_drop;
    logic [127:0] exp_q[$];
    bus.rcv_rdy = 1'b0;
    for (int p = 0; p < 3; p++)
      for (int b = 0; b < 5; b++) begin
        drive(b == 0, b == 0, mkd(p + 3, b), 8'h00);
        exp_q.push_back(mkd(p + 3, b));
        tick;
      end
    idle;
    total++; if (bus.rcv_free !== 5'd1) begin bad++; $display("FAIL drop_free15 got=%0d exp=1", bus.rcv_free); end
    drive(1'b1, 1'b1, mkd(7, 0), 8'h00);
    tick;
    total++; if (bus.drop_cnt !== 8'd1) begin bad++; $display("FAIL drop_cnt got=%0d exp=1", bus.drop_cnt); end
    for (int b = 1; b < 5; b++) begin
      drive(1'b0, 1'b0, mkd(7, b), 8'h01);
      tick;
    end
    total++; if (bus.rcv_free !== 5'd1 || bus.perr_cnt !== 8'd1)
      begin bad++; $display("FAIL drop_nostore got=%0d/%0d exp=1/1", bus.rcv_free, bus.perr_cnt); end
    drive(1'b1, 1'b0, mkd(9, 0), 8'h00);
    exp_q.push_back(mkd(9, 0));
    tick;
    idle;
    total++; if (bus.rcv_free !== 5'd0 || bus.drop_cnt !== 8'd1)
      begin bad++; $display("FAIL drop_small_admit got=%0d/%0d exp=0/1", bus.rcv_free, bus.drop_cnt); end
    bus.rcv_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++; if (bus.rcv_vld !== 1'b1 || bus.rcv_data !== exp_q[i] || bus.rcv_sop !== (i % 5 == 0))
        begin bad++; $display("FAIL drain%0d got=%b/%h/%b exp=1/%h/%b", i, bus.rcv_vld, bus.rcv_data, bus.rcv_sop, exp_q[i], i % 5 == 0); end
      tick;
    end
    total++; if (bus.rcv_vld !== 1'b0 || bus.rcv_free !== 5'd16)
      begin bad++; $display("FAIL drain_end got=%b/%0d exp=0/16", bus.rcv_vld, bus.rcv_free); end
  endtask
  task automatic test_proto;
    bus.rcv_rdy = 1'b1;
    for (int b = 0; b < 5; b++) begin
      drive(b == 0 || b == 3, 1'b1, mkd(11, b), 8'h00);
      tick;
      total++; if (bus.err_proto !== (b == 3))
        begin bad++; $display("FAIL proto_pulse%0d got=%b exp=%b", b, bus.err_proto, b == 3); end
      total++; if (bus.rcv_vld !== 1'b1 || bus.rcv_data !== mkd(11, b) || {bus.rcv_sop, bus.rcv_eop} !== {b == 0, b == 4})
        begin bad++; $display("FAIL proto_beat%0d got=%b/%h/%b%b", b, bus.rcv_vld, bus.rcv_data, bus.rcv_sop, bus.rcv_eop); end
    end
    idle;
    tick;
    total++; if (bus.rcv_vld !== 1'b0 || bus.err_proto !== 1'b0 || bus.rcv_free !== 5'd16)
      begin bad++; $display("FAIL proto_end got=%b/%b/%0d exp=0/0/16", bus.rcv_vld, bus.err_proto, bus.rcv_free); end
  endtask
  task automatic test_async_reset;
    bus.rcv_rdy = 1'b0;
    drive(1'b1, 1'b1, mkd(12, 0), 8'h00);
    tick;
    drive(1'b0, 1'b0, mkd(12, 1), 8'h00);
    tick;
    drive(1'b0, 1'b0, mkd(12, 2), 8'h00);
    total++; if (bus.rcv_free !== 5'd14) begin bad++; $display("FAIL arst_pre got=%0d exp=14", bus.rcv_free); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.rcv_vld !== 1'b0 || bus.rcv_free !== 5'd16 || bus.perr_cnt !== 8'd0 || bus.drop_cnt !== 8'd0)
      begin bad++; $display("FAIL arst_now got=%b/%0d/%0d/%0d exp=0/16/0/0", bus.rcv_vld, bus.rcv_free, bus.perr_cnt, bus.drop_cnt); end
    tick;
    rst = 1'b0;
    drive(1'b0, 1'b0, mkd(12, 3), 8'h00);
    tick;
    drive(1'b0, 1'b0, mkd(12, 4), 8'h00);
    tick;
    idle;
    tick;
    total++; if (bus.rcv_vld !== 1'b0 || bus.rcv_free !== 5'd16)
      begin bad++; $display("FAIL arst_ignore got=%b/%0d exp=0/16", bus.rcv_vld, bus.rcv_free); end
  endtask
  initial begin
    bus.rcv_rdy = 1'b0;
    idle;
    test_reset;
    test_single_hdr;
    test_full_pkt;
    test_parity;
    test_drop;
    test_proto;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
